// File: rtl/adc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_pkg : shared types and frame constants for the MCP3008 arbiter    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam int FRAME_BITS = 17;
  localparam int CMD_BITS   = 5;
  localparam int NULL_EDGE  = 7;
  localparam int RESULT_W   = 10;
  localparam int BIT_CNT_W  = 5;

endpackage
`default_nettype wire

// File: rtl/adc_sclk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_sclk_gen : SCLK divider emitting rise/fall strobes while enabled  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module adc_sclk_gen #(
  parameter int HALF_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = $clog2(HALF_DIV);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sclk;
  logic             w_tc;

  assign w_tc = i_en && (r_cnt == CNT_W'(HALF_DIV - 1));

  // Disabling parks the divider so every frame starts with a full low half.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_tc) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  assign o_sclk = r_sclk;
  assign o_rise = w_tc && !r_sclk;
  assign o_fall = w_tc && r_sclk;

endmodule
`default_nettype wire

// File: rtl/adc_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_arbiter : round-robin sharing of one MCP3008 among NUM_REQ users  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module adc_arbiter
  import adc_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int HALF_DIV = 4,
  parameter int CS_IDLE  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ-1:0][2:0]    i_req_ch,
  input  logic [NUM_REQ-1:0]         i_req_sgl,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic                       o_done,
  output logic [$clog2(NUM_REQ)-1:0] o_done_id,
  output logic [RESULT_W-1:0]        o_data,
  output logic                       o_err,
  output logic                       o_adc_cs_n,
  output logic                       o_adc_sclk,
  output logic                       o_adc_din,
  input  logic                       i_adc_dout
);

  localparam int IDW   = $clog2(NUM_REQ);
  localparam int GAP_W = $clog2(CS_IDLE + 1);

  state_t                r_state, w_state_nxt;
  logic                  r_armed;
  logic [IDW-1:0]        r_ptr, r_id, r_done_id, w_win;
  logic                  w_found;
  logic [CMD_BITS-1:0]   r_cmd;
  logic [BIT_CNT_W-1:0]  r_bit, w_edge;
  logic                  r_null, r_err;
  logic [RESULT_W-1:0]   r_shift, r_data;
  logic [GAP_W-1:0]      r_gap;
  logic                  w_rise, w_fall, w_sclk_en, w_grant_now, w_last_fall;

  // Search starts one past the last served index; r_ptr resets to the top index.
  always_comb begin
    logic [IDW:0] w_sum;
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(i + 1);
      if (w_sum >= (IDW+1)'(NUM_REQ)) w_sum = w_sum - (IDW+1)'(NUM_REQ);
      if (!w_found && i_req[w_sum[IDW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[IDW-1:0];
      end
    end
  end

  assign w_sclk_en   = (r_state == SHIFT);
  assign w_grant_now = (r_state == IDLE) && r_armed && w_found;
  assign w_edge      = r_bit + BIT_CNT_W'(1);
  assign w_last_fall = w_sclk_en && w_fall && (r_bit == BIT_CNT_W'(FRAME_BITS - 1));

  adc_sclk_gen #(.HALF_DIV(HALF_DIV)) u_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_sclk_en),
    .o_sclk (o_adc_sclk),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_adc_cs_n  = 1'b1;
    o_adc_din   = 1'b0;
    o_grant     = '0;
    o_done      = 1'b0;
    case (r_state)
      IDLE:   if (w_grant_now) w_state_nxt = SHIFT;
      SHIFT: begin
        o_adc_cs_n     = 1'b0;
        o_adc_din      = r_cmd[CMD_BITS-1];
        o_grant[r_id]  = 1'b1;
        if (w_last_fall) w_state_nxt = FINISH;
      end
      FINISH: begin
        o_done      = 1'b1;
        w_state_nxt = (CS_IDLE <= 1) ? IDLE : GAP;
      end
      GAP:    if (r_gap >= GAP_W'(CS_IDLE)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_armed holds off the very first grant until the second edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed   <= 1'b0;
      r_ptr     <= IDW'(NUM_REQ - 1);
      r_id      <= '0;
      r_cmd     <= '0;
      r_bit     <= '0;
      r_null    <= 1'b0;
      r_shift   <= '0;
      r_data    <= '0;
      r_err     <= 1'b0;
      r_done_id <= '0;
      r_gap     <= '0;
    end else begin
      r_armed <= 1'b1;
      if (w_grant_now) begin
        r_id  <= w_win;
        r_ptr <= w_win;
        r_cmd <= {1'b1, i_req_sgl[w_win], i_req_ch[w_win]};
        r_bit <= '0;
      end
      if (w_sclk_en && w_fall) begin
        r_bit <= w_edge;
        r_cmd <= {r_cmd[CMD_BITS-2:0], 1'b0};
      end
      if (w_sclk_en && w_rise) begin
        if (w_edge == BIT_CNT_W'(NULL_EDGE))     r_null  <= i_adc_dout;
        else if (w_edge > BIT_CNT_W'(NULL_EDGE)) r_shift <= {r_shift[RESULT_W-2:0], i_adc_dout};
      end
      if (w_last_fall) begin
        r_data    <= r_shift;
        r_err     <= r_null;
        r_done_id <= r_id;
        r_gap     <= GAP_W'(1);
      end else if ((r_state == FINISH || r_state == GAP) && r_gap < GAP_W'(CS_IDLE)) begin
        r_gap <= r_gap + GAP_W'(1);
      end
    end
  end

  assign o_data    = r_data;
  assign o_err     = r_err;
  assign o_done_id = r_done_id;

endmodule
`default_nettype wire

// File: tb/tb_adc_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_adc_arbiter : directed self-checking bench with an MCP3008 model  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_adc_arbiter;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      req = '0;
  logic [3:0][2:0] req_ch = '0;
  logic [3:0]      req_sgl = '0;
  logic [3:0]      grant;
  logic            done;
  logic [1:0]      done_id;
  logic [9:0]      data;
  logic            err, cs_n, sclk, din;
  logic            dout = 1'b0;

  always #5 clk = ~clk;

  adc_arbiter #(.NUM_REQ(4), .HALF_DIV(4), .CS_IDLE(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (req),
    .i_req_ch   (req_ch),
    .i_req_sgl  (req_sgl),
    .o_grant    (grant),
    .o_done     (done),
    .o_done_id  (done_id),
    .o_data     (data),
    .o_err      (err),
    .o_adc_cs_n (cs_n),
    .o_adc_sclk (sclk),
    .o_adc_din  (din),
    .i_adc_dout (dout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ADC model and bus monitor, evaluated mid-cycle.
  int         gn = 0, dn = 0;
  logic [3:0] glog [0:31];
  int         gaplog [0:31];
  int         low_len = 0, last_low = 0, hi_len = 0, rises = 0, f = 0;
  logic [4:0] din_bits = '0;
  logic       prev_cs = 1'b1, prev_sclk = 1'b0;
  logic [1:0] d_id = '0;
  logic [9:0] d_data = '0;
  logic       d_err = 1'b0;
  logic [9:0] m_word = '0;
  logic       m_null = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cs = 1'b1; prev_sclk = 1'b0; f = 0; rises = 0; low_len = 0; hi_len = 0; dout = 1'b0;
    end else begin
      if (!cs_n) begin
        if (prev_cs) begin
          if (gn < 32) begin glog[gn] = grant; gaplog[gn] = hi_len; end
          gn++; low_len = 0; rises = 0; f = 0; din_bits = '0;
        end
        low_len++;
        if (!prev_sclk && sclk) begin
          rises++;
          if (rises <= 5) din_bits = {din_bits[3:0], din};
        end
        if (prev_sclk && !sclk) f++;
      end else begin
        if (!prev_cs) begin last_low = low_len; hi_len = 0; end
        hi_len++;
      end
      if (done) begin dn++; d_id = done_id; d_data = data; d_err = err; end
      if (f + 1 == 7)                 dout = m_null;
      else if (f >= 7 && f <= 16)     dout = m_word[4'(16 - f)];
      else                            dout = 1'b0;
      prev_cs = cs_n; prev_sclk = sclk;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_cs_n", cs_n, 1);
    check_eq("rst_sclk", sclk, 0);
    check_eq("rst_din", din, 0);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_data", data, 0);
    check_eq("rst_done_id", done_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("arm_first_edge_cs", cs_n, 1);
  endtask

  task automatic wait_dones(input int n, input int budget, input string tag);
    int start;
    int k;
    start = dn;
    k = 0;
    while (dn < start + n && k < budget) begin
      @(negedge clk); #1; k++;
    end
    check_eq(tag, 32'(dn >= start + n), 1);
  endtask

  task automatic wait_rises(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while ((cs_n || rises < n) && k < budget) begin
      @(negedge clk); #1; k++;
    end
    check_eq(tag, 32'(!cs_n && rises >= n), 1);
  endtask

  initial begin
    int g0;
    int d0;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    int g0;
    int d0;

    // Single request, single-ended channel 5
    do_reset();
    m_word = 10'h2A5; m_null = 1'b0;
    req_ch[1] = 3'd5; req_sgl[1] = 1'b1; req[1] = 1'b1;
    g0 = gn;
    wait_dones(1, 400, "t1_timeout");
    req = '0;
    check_eq("t1_grant", glog[g0], 4'b0010);
    check_eq("t1_din", din_bits, 5'b11101);
    check_eq("t1_cs_low", last_low, 136);
    check_eq("t1_done_id", d_id, 1);
    check_eq("t1_data", d_data, 10'h2A5);
    check_eq("t1_err", d_err, 0);
    @(negedge clk); #1;
    check_eq("t1_done_pulse", done, 0);

    // All four requesters held from reset
    req = 4'hF;
    m_word = 10'h0F0;
    g0 = gn;
    do_reset();
    wait_dones(5, 2000, "t2_timeout");
    req = '0;
    check_eq("t2_g0", glog[g0],     4'b0001);
    check_eq("t2_g1", glog[g0 + 1], 4'b0010);
    check_eq("t2_g2", glog[g0 + 2], 4'b0100);
    check_eq("t2_g3", glog[g0 + 3], 4'b1000);
    check_eq("t2_g4", glog[g0 + 4], 4'b0001);
    for (int i = 1; i <= 4; i++) check_eq("t2_gap", 32'(gaplog[g0 + i] >= 8), 1);

    // Null bit reads 1, differential channel 2
    do_reset();
    m_word = 10'h155; m_null = 1'b1;
    req_ch[3] = 3'd2; req_sgl[3] = 1'b0; req[3] = 1'b1;
    wait_dones(1, 400, "t3_timeout");
    req = '0;
    check_eq("t3_err", d_err, 1);
    check_eq("t3_data", d_data, 10'h155);
    check_eq("t3_done_id", d_id, 3);
    check_eq("t3_din", din_bits, 5'b10010);

    // Request withdrawn at SCLK edge 9
    do_reset();
    m_word = 10'h3C3; m_null = 1'b0;
    req_ch[2] = 3'd1; req_sgl[2] = 1'b1; req[2] = 1'b1;
    wait_rises(9, 400, "t4_rise_timeout");
    req[2] = 1'b0;
    g0 = gn;
    wait_dones(1, 400, "t4_timeout");
    check_eq("t4_done_id", d_id, 2);
    check_eq("t4_data", d_data, 10'h3C3);
    repeat (60) @(negedge clk);
    #1;
    check_eq("t4_no_regrant", gn, g0);

    // Reset asserted mid-frame at SCLK edge 10
    do_reset();
    req_ch[1] = 3'd0; req_sgl[1] = 1'b1; req[1] = 1'b1;
    wait_rises(2, 400, "t5_start_timeout");
    req[0] = 1'b1; req[3] = 1'b1;
    wait_rises(10, 400, "t5_rise_timeout");
    check_eq("t5_sclk_high", sclk, 1);
    #2;
    d0 = dn;
    rst_n = 1'b0;
    #1;
    check_eq("t5_cs_n", cs_n, 1);
    check_eq("t5_sclk", sclk, 0);
    check_eq("t5_grant", grant, 0);
    repeat (3) @(negedge clk);
    #1;
    check_eq("t5_no_done", dn, d0);
    rst_n = 1'b1;
    g0 = gn;
    m_word = 10'h001;
    wait_dones(1, 400, "t5_timeout");
    req = '0;
    check_eq("t5_first_grant", glog[g0], 4'b0001);
    check_eq("t5_done_id", d_id, 0);
    check_eq("t5_data", d_data, 10'h001);

    // Channel select changed after grant
    do_reset();
    m_word = 10'h200;
    req_ch[2] = 3'd3; req_sgl[2] = 1'b1; req[2] = 1'b1;
    wait_rises(0, 400, "t6_start_timeout");
    @(negedge clk); #1;
    req_ch[2] = 3'd6; req_sgl[2] = 1'b0;
    wait_dones(1, 400, "t6_timeout");
    req = '0;
    check_eq("t6_din", din_bits, 5'b11011);
    check_eq("t6_done_id", d_id, 2);
    check_eq("t6_data", d_data, 10'h200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adc_arbiter.md
ADC_ARBITER -- requirements
Module: adc_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the MCP3008 ADC (2..8).
REQ-002 Parameter HALF_DIV, default 4: clk cycles per SCLK half-period (>=2).
REQ-003 Parameter CS_IDLE, default 8: minimum clk cycles adc_cs_n stays high between frames.
REQ-004 clk  in  1  single system clock; all logic on posedge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req  in  NUM_REQ  per-requester conversion request, level, held until done.
REQ-007 req_ch  in  NUM_REQ x 3  per-requester channel select D2..D0.
REQ-008 req_sgl  in  NUM_REQ  per-requester single-ended (1) / differential (0) select.
REQ-009 grant  out  NUM_REQ  one-hot, high for the whole frame of the served requester.
REQ-010 done  out  1  one-cycle pulse, result valid.
REQ-011 done_id  out  $clog2(NUM_REQ)  index of the requester the result belongs to.
REQ-012 data  out  10  conversion result B9..B0, held until the next done.
REQ-013 err  out  1  valid with done; the null bit was read as 1.
REQ-014 adc_cs_n  out  1  ADC chip select, active low.
REQ-015 adc_sclk  out  1  ADC serial clock, idles low.
REQ-016 adc_din  out  1  command bits to the ADC.
REQ-017 adc_dout  in  1  serial data from the ADC, treated as synchronous to clk.

Function
REQ-018 The FSM SHALL have four states: IDLE, SHIFT, FINISH, GAP.
REQ-019 IDLE SHALL sample req; when any bit is set, it SHALL register the round-robin winner next cycle: grant one-hot, adc_cs_n=0, adc_din=1 (start bit), state SHIFT.
REQ-020 Round-robin SHALL search from (last served index + 1) mod NUM_REQ; after reset the search SHALL start at index 0.
REQ-021 The winner's req_ch and req_sgl SHALL be captured at grant; later changes SHALL NOT affect the frame.
REQ-022 SHIFT SHALL generate 17 SCLK periods; each period is HALF_DIV cycles low followed by HALF_DIV cycles high, so adc_cs_n is low for 34*HALF_DIV cycles.
REQ-023 adc_din SHALL present start, sgl, D2, D1, D0 for periods 1..5, changing only on SCLK falling edges; it SHALL be 0 from period 6 onward.
REQ-024 adc_dout SHALL be sampled on the clk cycle of each SCLK rising edge: edge 7 is the null bit, and edges 8..17 are B9..B0, MSB first.
REQ-025 After the 17th falling edge the FSM SHALL enter FINISH for one cycle, which does the following in that same cycle: adc_cs_n=1, grant=0, done=1, data/done_id/err updated.
REQ-026 GAP SHALL hold adc_cs_n high for CS_IDLE cycles total (the FINISH cycle counts) before returning to IDLE.
REQ-027 If req of the granted requester drops mid-frame, the frame SHALL still complete and done SHALL still pulse.
REQ-028 A requester still holding req at done SHALL be treated as a new request, subject to round-robin.
REQ-029 Requests arriving during SHIFT/FINISH/GAP SHALL wait; none SHALL be lost while held.
REQ-030 Counters SHALL be sized from the parameters; the bit counter SHALL be 5 bits (0..17), and nothing SHALL wrap.

Reset
REQ-031 On rst_n low, the following SHALL apply immediately, mid-frame included: adc_cs_n=1, adc_sclk=0, adc_din=0, grant=0, done=0, err=0, data=0, done_id=0, state IDLE, RR pointer set so index 0 is searched first.
REQ-032 The first frame after reset release SHALL start no earlier than the second clk edge.

Structure
REQ-033 Package adc_pkg SHALL hold the state enum, FRAME_BITS=17, CMD_BITS=5, NULL_EDGE=7 and the result width of 10.
REQ-034 SCLK timing SHALL be a sub-module adc_sclk_gen that emits rise/fall strobes from HALF_DIV under an enable.
REQ-035 The round-robin arbiter SHALL be combinational, with a registered pointer inside adc_arbiter.

Verification
REQ-036 Single request: req[1]=1, req_ch[1]=5, sgl=1; the DOUT model returns 0x2A5, null=0 -> adc_din bits 1,1,1,0,1; cs_n low 136 cycles; done, done_id=1, data=0x2A5, err=0.
REQ-037 All four req high from reset -> grants in order 0,1,2,3,0; cs_n-high gaps >=8 cycles.
REQ-038 The DOUT model drives null=1 -> done with err=1; data is still captured.
REQ-039 req[2] dropped at SCLK edge 9 -> frame completes and done_id=2; no new grant to 2.
REQ-040 rst_n asserted at SCLK edge 10 -> cs_n=1 and sclk=0 within the same cycle, no done; after release a held req[0] is served first.
REQ-041 req_ch changed mid-frame -> din bits match the value captured at grant.
